// File: rtl/memory_model_pkg.sv
// -----------------------------------------------------------------------------
// memory_model_pkg
// Shared types and helpers for the dual-port OBI memory model.
//   rsp_t       : one response beat (valid, err, data), sized for the widest
//                 supported word (8 bytes); narrower words use the low bits.
//   word_index(): byte address -> word index (drop byte offset, keep index bits).
//   LFSR_TAPS   : Fibonacci taps 16,14,13,11 for the optional grant stall LFSR.
// -----------------------------------------------------------------------------
package memory_model_pkg;

  localparam int unsigned MAX_READ_LATENCY = 4;
  localparam int unsigned MAX_DATA_W       = 64;
  localparam logic [15:0] LFSR_TAPS        = 16'hB400;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [MAX_DATA_W-1:0] data;
  } rsp_t;

  function automatic int unsigned word_index(input logic [63:0]  addr,
                                             input int unsigned  off_w,
                                             input int unsigned  idx_w);
    logic [63:0] shifted;
    logic [63:0] mask;
    shifted = addr >> off_w;
    mask    = (64'd1 << idx_w) - 64'd1;
    return 32'(shifted & mask);
  endfunction

endpackage

// File: rtl/memory_model_rsp_pipe.sv
// -----------------------------------------------------------------------------
// memory_model_rsp_pipe
// LATENCY-stage shift register of response beats. The head stage is loaded on
// every clock (an empty beat when nothing was accepted), so the tail presents
// either a response or all-zeros. Async reset drops everything in flight.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   i_rsp  response beat captured at the accept edge
//   o_rsp  response beat LATENCY cycles later
// -----------------------------------------------------------------------------
module memory_model_rsp_pipe
  import memory_model_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  rsp_t i_rsp,
  output rsp_t o_rsp
);

  // Clamp into the supported 1..MAX_READ_LATENCY range.
  localparam int unsigned STAGES = (LATENCY < 1) ? 1 :
                                   ((LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : LATENCY);

  rsp_t r_stage [STAGES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < int'(STAGES); k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= i_rsp;
      for (int k = 1; k < int'(STAGES); k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign o_rsp = r_stage[STAGES-1];

endmodule

// File: rtl/memory_model_dp_obi.sv
// -----------------------------------------------------------------------------
// memory_model_dp_obi
// Dual-port on-chip memory model with OBI-style req/gnt/rvalid handshakes.
// Port A is read-write with byte enables, port B is read-only. Responses come
// back READ_LATENCY cycles after the accept edge, fully pipelined and in order.
// Out-of-range accesses touch no memory and answer err=1, rdata=0. When A
// writes and B reads the same word in one cycle, B sees the old word.
// Memory contents are not reset.
//
// Optional build macro MEMORY_MODEL_STALL_EN: a 16-bit Fibonacci LFSR gates
// the grants (a_gnt = a_req & lfsr[0], b_gnt = b_req & lfsr[1]). Without it
// grants equal requests combinationally.
//
// Ports:
//   clk_i, rst_i                     clock / async active-high reset
//   a_req_i/a_gnt_o                  port A handshake
//   a_addr_i, a_we_i, a_be_i,        port A byte address, write enable,
//   a_wdata_i                        byte enables, write data
//   a_rvalid_o, a_rdata_o, a_err_o   port A response
//   b_req_i/b_gnt_o, b_addr_i        port B handshake and byte address
//   b_rvalid_o, b_rdata_o, b_err_o   port B response
// -----------------------------------------------------------------------------
module memory_model_dp_obi
  import memory_model_pkg::*;
#(
  parameter int unsigned WORD_SIZE_BYTE = 4,
  parameter int unsigned SIZE_IN_KB     = 8,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter logic [15:0] STALL_SEED     = 16'hACE1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        a_req_i,
  output logic                        a_gnt_o,
  input  logic [ADDR_WIDTH-1:0]       a_addr_i,
  input  logic                        a_we_i,
  input  logic [WORD_SIZE_BYTE-1:0]   a_be_i,
  input  logic [8*WORD_SIZE_BYTE-1:0] a_wdata_i,
  output logic                        a_rvalid_o,
  output logic [8*WORD_SIZE_BYTE-1:0] a_rdata_o,
  output logic                        a_err_o,
  input  logic                        b_req_i,
  output logic                        b_gnt_o,
  input  logic [ADDR_WIDTH-1:0]       b_addr_i,
  output logic                        b_rvalid_o,
  output logic [8*WORD_SIZE_BYTE-1:0] b_rdata_o,
  output logic                        b_err_o
);

  localparam int unsigned DATA_W = 8 * WORD_SIZE_BYTE;
  localparam int unsigned DEPTH  = SIZE_IN_KB * 1024 / WORD_SIZE_BYTE;
  localparam int unsigned OFF_W  = $clog2(WORD_SIZE_BYTE);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(SIZE_IN_KB * 1024);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_a_acc, w_b_acc;
  logic              w_a_oor, w_b_oor;
  logic [IDX_W-1:0]  w_a_idx, w_b_idx;
  logic [DATA_W-1:0] w_a_rd,  w_b_rd;
  rsp_t              w_a_rsp_in, w_b_rsp_in;
  rsp_t              w_a_rsp,    w_b_rsp;

  // Grant generation
`ifdef MEMORY_MODEL_STALL_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_lfsr <= STALL_SEED;
    else       r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end

  assign a_gnt_o = a_req_i & r_lfsr[0];
  assign b_gnt_o = b_req_i & r_lfsr[1];
`else
  localparam logic [15:0] stall_seed_unused = STALL_SEED;

  assign a_gnt_o = a_req_i;
  assign b_gnt_o = b_req_i;
`endif

  assign w_a_acc = a_req_i & a_gnt_o;
  assign w_b_acc = b_req_i & b_gnt_o;

  // Address decode: byte offset dropped, anything at or past the end is an error
  assign w_a_idx = IDX_W'(word_index(64'(a_addr_i), OFF_W, IDX_W));
  assign w_b_idx = IDX_W'(word_index(64'(b_addr_i), OFF_W, IDX_W));
  assign w_a_oor = ({1'b0, a_addr_i} >= MEM_BYTES);
  assign w_b_oor = ({1'b0, b_addr_i} >= MEM_BYTES);

  // Reads see the array before this edge's write lands: read-first on collision.
  assign w_a_rd = (w_a_acc && !a_we_i && !w_a_oor) ? r_mem[w_a_idx] : '0;
  assign w_b_rd = (w_b_acc && !w_b_oor)            ? r_mem[w_b_idx] : '0;

  always_ff @(posedge clk_i) begin
    if (w_a_acc && a_we_i && !w_a_oor) begin
      for (int i = 0; i < int'(WORD_SIZE_BYTE); i++) begin
        if (a_be_i[i]) r_mem[w_a_idx][8*i +: 8] <= a_wdata_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_a_rsp_in       = '0;
    w_a_rsp_in.valid = w_a_acc;
    w_a_rsp_in.err   = w_a_acc & w_a_oor;
    w_a_rsp_in.data  = MAX_DATA_W'(w_a_rd);
    w_b_rsp_in       = '0;
    w_b_rsp_in.valid = w_b_acc;
    w_b_rsp_in.err   = w_b_acc & w_b_oor;
    w_b_rsp_in.data  = MAX_DATA_W'(w_b_rd);
  end

  // Response pipelines: one per port
  memory_model_rsp_pipe #(.LATENCY(READ_LATENCY)) u_a_pipe (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_rsp (w_a_rsp_in),
    .o_rsp (w_a_rsp)
  );

  memory_model_rsp_pipe #(.LATENCY(READ_LATENCY)) u_b_pipe (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_rsp (w_b_rsp_in),
    .o_rsp (w_b_rsp)
  );

  assign a_rvalid_o = w_a_rsp.valid;
  assign a_err_o    = w_a_rsp.err;
  assign a_rdata_o  = w_a_rsp.data[DATA_W-1:0];
  assign b_rvalid_o = w_b_rsp.valid;
  assign b_err_o    = w_b_rsp.err;
  assign b_rdata_o  = w_b_rsp.data[DATA_W-1:0];

  // Upper beat bits are always zero for words narrower than the beat.
  if (DATA_W < MAX_DATA_W) begin : g_pad
    logic w_pad_unused;
    assign w_pad_unused = ^{w_a_rsp.data[MAX_DATA_W-1:DATA_W],
                            w_b_rsp.data[MAX_DATA_W-1:DATA_W]};
  end

endmodule

// File: tb/tb_memory_model_dp_obi.sv
// Two instances (READ_LATENCY 1 and 3) share one stimulus stream; each is
// checked against its own latency.
module tb_memory_model_dp_obi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0;
  logic [3:0]  a_be = '0;

  logic        a1_gnt, a1_rvalid, a1_err, b1_gnt, b1_rvalid, b1_err;
  logic [31:0] a1_rdata, b1_rdata;
  logic        a3_gnt, a3_rvalid, a3_err, b3_gnt, b3_rvalid, b3_err;
  logic [31:0] a3_rdata, b3_rdata;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  memory_model_dp_obi #(.READ_LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_gnt_o(a1_gnt), .a_addr_i(a_addr), .a_we_i(a_we),
    .a_be_i(a_be), .a_wdata_i(a_wdata), .a_rvalid_o(a1_rvalid),
    .a_rdata_o(a1_rdata), .a_err_o(a1_err),
    .b_req_i(b_req), .b_gnt_o(b1_gnt), .b_addr_i(b_addr),
    .b_rvalid_o(b1_rvalid), .b_rdata_o(b1_rdata), .b_err_o(b1_err)
  );

  memory_model_dp_obi #(.READ_LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_gnt_o(a3_gnt), .a_addr_i(a_addr), .a_we_i(a_we),
    .a_be_i(a_be), .a_wdata_i(a_wdata), .a_rvalid_o(a3_rvalid),
    .a_rdata_o(a3_rdata), .a_err_o(a3_err),
    .b_req_i(b_req), .b_gnt_o(b3_gnt), .b_addr_i(b_addr),
    .b_rvalid_o(b3_rvalid), .b_rdata_o(b3_rdata), .b_err_o(b3_err)
  );

  typedef struct {
    bit          a_req;
    bit          a_we;
    logic [31:0] a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_wdata;
    bit          b_req;
    logic [31:0] b_addr;
    logic [31:0] exp_a;
    bit          exp_a_err;
    logic [31:0] exp_b;
    bit          exp_b_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic chk_port(input string nm, input logic v, input logic [31:0] d, input logic e,
                          input bit exp_v, input logic [31:0] exp_d, input bit exp_e);
    chk({nm, ".rvalid"}, {31'd0, v}, {31'd0, exp_v});
    if (exp_v) begin
      chk({nm, ".rdata"}, d, exp_d);
      chk({nm, ".err"}, {31'd0, e}, {31'd0, exp_e});
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".outs"},
        {20'd0, a1_rvalid, a1_err, b1_rvalid, b1_err, a3_rvalid, a3_err, b3_rvalid, b3_err,
         4'd0} | a1_rdata | b1_rdata | a3_rdata | b3_rdata, 32'd0);
  endtask

  // Drive one transaction, hold it until granted, return just after the accept edge.
  task automatic issue(input string nm, input vec_t v);
    int waits;
    waits = 0;
    @(negedge clk);
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_be = v.a_be; a_wdata = v.a_wdata;
    b_req = v.b_req; b_addr = v.b_addr;
    #1;
    while (!((!v.a_req || a1_gnt) && (!v.b_req || b1_gnt))) begin
      if (waits == 200) begin
        chk({nm, ".gnt_timeout"}, 32'd0, 32'd1);
        break;
      end
      @(negedge clk); #1;
      waits++;
    end
`ifndef MEMORY_MODEL_STALL_EN
    chk({nm, ".a_gnt"}, {30'd0, a3_gnt, a1_gnt}, {30'd0, v.a_req, v.a_req});
    chk({nm, ".b_gnt"}, {30'd0, b3_gnt, b1_gnt}, {30'd0, v.b_req, v.b_req});
`endif
    @(posedge clk);
  endtask

  // Response window: LAT1 answers on sample 1, LAT3 on sample 3, nothing else.
  task automatic check_rsp(input string nm, input vec_t v);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk_port({nm, ".A1"}, a1_rvalid, a1_rdata, a1_err, v.a_req && k == 1, v.exp_a, v.exp_a_err);
      chk_port({nm, ".A3"}, a3_rvalid, a3_rdata, a3_err, v.a_req && k == 3, v.exp_a, v.exp_a_err);
      chk_port({nm, ".B1"}, b1_rvalid, b1_rdata, b1_err, v.b_req && k == 1, v.exp_b, v.exp_b_err);
      chk_port({nm, ".B3"}, b3_rvalid, b3_rdata, b3_err, v.b_req && k == 3, v.exp_b, v.exp_b_err);
      if (k == 1) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[20];
    vec_t v;

    // Reset state
    @(negedge clk);
    chk_all_zero("reset");
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0;
    #1;
`ifndef MEMORY_MODEL_STALL_EN
    chk("reset.gnt", {28'd0, a1_gnt, b1_gnt, a3_gnt, b3_gnt}, 32'hF);
`endif
    @(negedge clk);
    chk_all_zero("reset.held");
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

`ifndef MEMORY_MODEL_STALL_EN
    //           areq we addr           be    wdata          breq baddr          exp_a        ae exp_b        be
    vecs[0]  = '{1, 1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 0, 32'h0,         32'h0,        0, 32'h0,        0};
    vecs[1]  = '{1, 0, 32'h0000_0010, 4'h0, 32'h0,        0, 32'h0,         32'hDEADBEEF, 0, 32'h0,        0};
    vecs[2]  = '{1, 1, 32'h0000_0020, 4'hF, 32'hFFFFFFFF, 0, 32'h0,         32'h0,        0, 32'h0,        0};
    vecs[3]  = '{1, 1, 32'h0000_0020, 4'h5, 32'h11223344, 0, 32'h0,         32'h0,        0, 32'h0,        0};
    vecs[4]  = '{1, 0, 32'h0000_0020, 4'h0, 32'h0,        0, 32'h0,         32'hFF22FF44, 0, 32'h0,        0};
    vecs[5]  = '{1, 1, 32'h0000_0040, 4'hF, 32'hAAAA0000, 0, 32'h0,         32'h0,        0, 32'h0,        0};
    vecs[6]  = '{1, 1, 32'h0000_0040, 4'hF, 32'h5555FFFF, 1, 32'h0000_0040, 32'h0,        0, 32'hAAAA0000, 0};
    vecs[7]  = '{0, 0, 32'h0,         4'h0, 32'h0,        1, 32'h0000_0040, 32'h0,        0, 32'h5555FFFF, 0};
    vecs[8]  = '{1, 1, 32'h0000_0000, 4'hF, 32'hCAFEF00D, 0, 32'h0,         32'h0,        0, 32'h0,        0};
    vecs[9]  = '{1, 1, 32'h0000_0004, 4'hF, 32'h00000004, 0, 32'h0,         32'h0,        0, 32'h0,        0};
    vecs[10] = '{1, 1, 32'h0000_0008, 4'hF, 32'h00000008, 0, 32'h0,         32'h0,        0, 32'h0,        0};
    vecs[11] = '{1, 1, 32'h0000_000C, 4'hF, 32'h0000000C, 0, 32'h0,         32'h0,        0, 32'h0,        0};
    vecs[12] = '{0, 0, 32'h0,         4'h0, 32'h0,        1, 32'h0000_2000, 32'h0,        0, 32'h0,        1};
    vecs[13] = '{1, 1, 32'h0000_2000, 4'hF, 32'h12345678, 0, 32'h0,         32'h0,        1, 32'h0,        0};
    vecs[14] = '{1, 0, 32'h0000_0000, 4'h0, 32'h0,        1, 32'h0000_0013, 32'hCAFEF00D, 0, 32'hDEADBEEF, 0};
    vecs[15] = '{1, 1, 32'h0000_0010, 4'h0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        0};
    vecs[16] = '{1, 0, 32'h0000_0010, 4'h0, 32'h0,        1, 32'h0000_0020, 32'hDEADBEEF, 0, 32'hFF22FF44, 0};
    vecs[17] = '{1, 1, 32'h0000_1FFC, 4'hF, 32'h77771FFC, 0, 32'h0,         32'h0,        0, 32'h0,        0};
    vecs[18] = '{1, 0, 32'hFFFF_FFFC, 4'h0, 32'h0,        1, 32'h0000_1FFC, 32'h0,        1, 32'h77771FFC, 0};
    vecs[19] = '{1, 0, 32'h0000_0004, 4'h0, 32'h0,        1, 32'h0000_0008, 32'h00000004, 0, 32'h00000008, 0};

    for (int i = 0; i < 20; i++) begin
      issue($sformatf("v%0d", i), vecs[i]);
      check_rsp($sformatf("v%0d", i), vecs[i]);
    end

    // Back-to-back on A: write then read-after-write, then four reads
    begin
      logic        bw [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [31:0] ba [6] = '{32'h30, 32'h30, 32'h0, 32'h4, 32'h8, 32'hC};
      logic [31:0] be [6] = '{32'h0, 32'h0BADCAFE, 32'hCAFEF00D, 32'h4, 32'h8, 32'hC};
      @(negedge clk);
      a_req = 1'b1; a_we = bw[0]; a_addr = ba[0]; a_be = 4'hF; a_wdata = 32'h0BADCAFE;
      for (int s = 0; s <= 8; s++) begin
        @(posedge clk);
        @(negedge clk);
        chk_port($sformatf("burst%0d.A1", s), a1_rvalid, a1_rdata, a1_err,
                 s <= 5, (s <= 5) ? be[(s <= 5) ? s : 0] : 32'h0, 1'b0);
        chk_port($sformatf("burst%0d.A3", s), a3_rvalid, a3_rdata, a3_err,
                 s >= 2 && s <= 7, be[(s >= 2 && s <= 7) ? s - 2 : 0], 1'b0);
        if (s < 5) begin
          a_we = bw[s+1]; a_addr = ba[s+1];
        end else begin
          a_req = 1'b0; a_we = 1'b0;
        end
      end
    end

    // Reset asserted with responses still in flight
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0;
    @(posedge clk);
    @(negedge clk);
    a_addr = 32'h4;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; a_req = 1'b0;
    #1;
    chk_all_zero("midrst.now");
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (s == 1) rst = 1'b0;
      chk_all_zero($sformatf("midrst.c%0d", s));
    end

    v = '{1, 0, 32'h10, 4'h0, 32'h0, 0, 32'h0, 32'hDEADBEEF, 0, 32'h0, 0};
    issue("postrst", v);
    check_rsp("postrst", v);
`else
    begin
      logic [31:0] model [16];
      for (int i = 0; i < 16; i++) begin
        model[i] = $urandom;
        v = '{1, 1, 32'(i * 4), 4'hF, model[i], 0, 32'h0, 32'h0, 0, 32'h0, 0};
        issue($sformatf("init%0d", i), v);
        check_rsp($sformatf("init%0d", i), v);
      end
      for (int n = 0; n < 1000; n++) begin
        int unsigned idx;
        bit          oor;
        logic [31:0] addr;
        idx  = $urandom_range(0, 15);
        oor  = ($urandom_range(0, 15) == 0);
        addr = oor ? 32'h2000 + 32'(idx * 4) : 32'(idx * 4);
        v = '{0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0};
        if ($urandom_range(0, 1) == 1) begin
          v.a_req   = 1'b1;
          v.a_we    = ($urandom_range(0, 1) == 1);
          v.a_addr  = addr;
          v.a_be    = 4'($urandom);
          v.a_wdata = $urandom;
          v.exp_a_err = oor;
          if (!oor && !v.a_we) v.exp_a = model[idx];
          if (!oor && v.a_we) begin
            for (int l = 0; l < 4; l++)
              if (v.a_be[l]) model[idx][8*l +: 8] = v.a_wdata[8*l +: 8];
          end
        end else begin
          v.b_req     = 1'b1;
          v.b_addr    = addr;
          v.exp_b_err = oor;
          if (!oor) v.exp_b = model[idx];
        end
        issue($sformatf("rnd%0d", n), v);
        check_rsp($sformatf("rnd%0d", n), v);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
